memory_loader: RTL
==================

// Module: memory_loader
// PURPOSE
//  Write-side companion to the word-addressed Memory block: accepts a stream of words over a
//  valid/ready handshake and writes them to consecutive Memory addresses from a base address,
//  reading each word back the cycle after writing it to confirm it was stored.
//  Sits between a data source (testbench, DMA, host) and Memory; drives Memory's Status/Address/I
//  ports and samples Memory's Q. It preloads tables that a pointer-walk or other reader then traverses.
// PARAMETERS
//  WordSize      32                        data width, equal to Memory WordSize
//  WordsNumber   8                         memory depth, equal to Memory WordsNumber
//  AddressWidth  $clog2(WordsNumber)       address width
// PORTS
//  Clock         in   1               single clock; all state updates on posedge
//  ResetN        in   1               asynchronous, active-low reset
//  Start         in   1               begin a load job (sampled in IDLE only)
//  BaseAddr      in   AddressWidth    first address written
//  Count         in   AddressWidth+1  number of words to load (0..WordsNumber)
//  DataValid     in   1               source holds a valid word
//  DataReady     out  1               loader will accept the word this cycle
//  Data          in   WordSize        stream word
//  MemStatus     out  1               to Memory Status: 1 = write, 0 = read
//  MemAddress    out  AddressWidth    to Memory Address
//  MemI          out  WordSize        to Memory I
//  MemQ          in   WordSize        from Memory Q (combinational read of MemAddress)
//  Busy          out  1               job in progress
//  Done          out  1               one-cycle pulse at job end
//  Error         out  1               sticky readback mismatch flag for current/last job
//  ErrorAddress  out  AddressWidth    address of the first mismatch
// BEHAVIOUR
//  - Reset (ResetN=0, asynchronous): state IDLE; all outputs 0; address/count registers 0.
//  - All outputs are registered. States are IDLE, LOAD, WRITE, CHECK and FIN.
//  - IDLE: Start=1 and Count!=0 -> latch BaseAddr and Count, clear Error and ErrorAddress,
//    Busy<=1, go to LOAD. Start=1 and Count==0 -> Done pulses 1 cycle, stay in IDLE.
//  - LOAD: DataReady=1 and MemStatus=0. On DataValid&DataReady at an edge, latch Data into MemI
//    and go to WRITE. DataValid=0 -> wait indefinitely; there is no timeout.
//  - WRITE: MemStatus=1, MemAddress=current address, MemI held; one cycle; go to CHECK.
//  - CHECK: MemStatus=0, same address. Compare MemQ with MemI.
//    On mismatch with Error=0: set Error and latch ErrorAddress. Later mismatches leave
//    ErrorAddress unchanged. The job continues after a mismatch.
//    Then decrement remaining count. Remaining was 1 -> FIN. Otherwise advance address -> LOAD.
//  - FIN: Done=1 for exactly 1 cycle, Busy<=0, go to IDLE. Error holds until the next accepted Start.
//  - Throughput: 3 cycles per word when DataValid is held high (LOAD, WRITE, CHECK).
//  - DataReady=0 in every state except LOAD. Start is ignored while Busy=1.
//  - Address arithmetic is modulo WordsNumber: WordsNumber-1 wraps to 0. This holds for
//    non-power-of-2 depths as well.
//  - Count > WordsNumber: clamp to WordsNumber at latch time.
//  - Count == WordsNumber with any BaseAddr: every location is written exactly once.
//  - Reset mid-job: immediate return to IDLE. Memory contents are partially written; no Done pulse.
//  - MemStatus is never 1 outside WRITE, so Memory is write-protected while idle.
// STRUCTURE
//  - Shared package memory_pkg: state encoding constants (IDLE, LOAD, WRITE, CHECK, FIN) and
//    Memory Status encoding (STATUS_READ=0, STATUS_WRITE=1). Reuse in the Memory and reader blocks.
//  - Sub-module mod_counter #(Modulus, Width): loadable modulo address counter with increment enable.
//  - Top level holds the FSM, remaining-count register, data register and error capture.
// TESTING (bench instantiates Memory #(32,8) wired to the loader; ClockGenerator #(50))
//  - Reset: ResetN=0 mid-simulation -> all outputs 0 immediately. Release and hold Start=0 ->
//    no Memory write occurs.
//  - Basic load: BaseAddr=0, Count=8, stream 4,1,3,4,2,5,6,0 ->
//    Memory[0..7] = 4,1,3,4,2,5,6,0; Done pulses once; Error=0; 24 cycles from first accept to FIN.
//  - Wrap: BaseAddr=6, Count=4, data 10,11,12,13 -> Memory[6]=10, [7]=11, [0]=12, [1]=13.
//  - Backpressure: DataValid toggled 1/0 every 2 cycles -> each word accepted only when
//    DataValid&DataReady; no word lost or duplicated; DataReady=0 during WRITE and CHECK.
//  - Fault: bench forces MemQ=0xDEAD at address 3 -> Error=1, ErrorAddress=3; the job completes.
//    The next Start clears Error.
//  - Edge cases: Count=0 -> Done pulses next cycle, Busy stays 0. Start asserted during a job is
//    ignored. Reset during WRITE -> IDLE, no Done pulse.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared definitions for the Memory block and its companions (loader, readers):
// controller state encoding and the Memory Status port encoding.
package memory_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    CHECK = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam logic STATUS_READ  = 1'b0;
  localparam logic STATUS_WRITE = 1'b1;

endpackage

// File: rtl/mod_counter.sv
// Loadable modulo counter: load has priority over increment, and the count
// wraps from Modulus-1 to 0 even when Modulus is not a power of two.
module mod_counter #(
  parameter int Modulus = 8,
  parameter int Width   = $clog2(Modulus)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  input  logic             en,
  output logic [Width-1:0] value
);

  localparam logic [Width-1:0] LastValue = Width'(Modulus - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (en) begin
      value <= (value == LastValue) ? '0 : value + Width'(1);
    end
  end

endmodule

// File: rtl/memory_loader.sv
// Streams words from a valid/ready source into consecutive Memory addresses,
// reading each one back the cycle after it is written and flagging the first mismatch.
module memory_loader
  import memory_pkg::*;
#(
  parameter int WordSize     = 32,
  parameter int WordsNumber  = 8,
  parameter int AddressWidth = $clog2(WordsNumber)
) (
  input  logic                    Clock,
  input  logic                    ResetN,
  input  logic                    Start,
  input  logic [AddressWidth-1:0] BaseAddr,
  input  logic [AddressWidth:0]   Count,
  input  logic                    DataValid,
  output logic                    DataReady,
  input  logic [WordSize-1:0]     Data,
  output logic                    MemStatus,
  output logic [AddressWidth-1:0] MemAddress,
  output logic [WordSize-1:0]     MemI,
  input  logic [WordSize-1:0]     MemQ,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Error,
  output logic [AddressWidth-1:0] ErrorAddress
);

  localparam logic [AddressWidth:0] MaxCount = (AddressWidth + 1)'(WordsNumber);
  localparam logic [AddressWidth:0] OneWord  = (AddressWidth + 1)'(1);

  state_t                  state, state_next;
  logic [AddressWidth:0]   remaining;
  logic [AddressWidth:0]   count_clamped;
  logic [AddressWidth-1:0] address;
  logic                    start_job, start_empty, accept, last_word, mismatch, advance;

  assign start_job     = (state == IDLE) && Start && (Count != '0);
  assign start_empty   = (state == IDLE) && Start && (Count == '0);
  assign accept        = (state == LOAD) && DataValid && DataReady;
  assign last_word     = (remaining == OneWord);
  assign mismatch      = (state == CHECK) && (MemQ != MemI);
  assign advance       = (state == CHECK) && !last_word;
  assign count_clamped = (Count > MaxCount) ? MaxCount : Count;
  assign MemAddress    = address;

  mod_counter #(
    .Modulus(WordsNumber),
    .Width  (AddressWidth)
  ) addr_counter (
    .clk       (Clock),
    .rst_n     (ResetN),
    .load      (start_job),
    .load_value(BaseAddr),
    .en        (advance),
    .value     (address)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_job) state_next = LOAD;
      LOAD:    if (accept) state_next = WRITE;
      WRITE:   state_next = CHECK;
      CHECK:   state_next = last_word ? FIN : LOAD;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake and Memory controls are registered from the next state so they line up with it.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state        <= IDLE;
      remaining    <= '0;
      DataReady    <= 1'b0;
      MemStatus    <= STATUS_READ;
      MemI         <= '0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Error        <= 1'b0;
      ErrorAddress <= '0;
    end else begin
      state     <= state_next;
      DataReady <= (state_next == LOAD);
      MemStatus <= (state_next == WRITE) ? STATUS_WRITE : STATUS_READ;
      Busy      <= (state_next != IDLE);
      Done      <= (state_next == FIN) || start_empty;
      if (accept) MemI <= Data;
      if (start_job) begin
        remaining    <= count_clamped;
        Error        <= 1'b0;
        ErrorAddress <= '0;
      end else begin
        if (state == CHECK) remaining <= remaining - OneWord;
        if (mismatch && !Error) begin
          Error        <= 1'b1;
          ErrorAddress <= address;
        end
      end
    end
  end

endmodule
